a2d_sched: RTL and testbench

A2D_SCHED -- requirements
Module: a2d_sched

---
 rtl/a2d_sched_pkg.sv | 29 ++
 rtl/a2d_sched_trig.sv | 37 +++
 rtl/a2d_sched.sv | 187 ++++++++++++++++++
 tb/tb_a2d_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_sched_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
package a2d_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    READ,
    LATCH
  } state_t;

  typedef logic [1:0] slot_t;

  localparam slot_t LAST_SLOT = 2'd3;

  // Channel per slot, packed 3 bits each: slot 0 in bits [2:0] ... slot 3 in [11:9]
  localparam logic [11:0] SLOT_CH_TBL = {3'd6, 3'd5, 3'd4, 3'd0};

  // Command word layout: {prefix, channel, pad}
  localparam logic [1:0]  CMD_PREFIX = 2'b00;
  localparam logic [10:0] CMD_PAD    = 11'h000;

  function automatic logic [15:0] slot_cmd(input slot_t s);
    logic [2:0] ch;
    ch = SLOT_CH_TBL[int'(s) * 3 +: 3];
    return {CMD_PREFIX, ch, CMD_PAD};
  endfunction

endpackage

// File: rtl/a2d_sched_trig.sv
// Conversion trigger: free-running period counter merged with the external
// nxt pulse into a single one-deep pending flag.
module a2d_sched_trig #(
  parameter logic [15:0] PERIOD_CYC = 16'd2048
) (
  input  logic clk,
  input  logic rst,
  input  logic nxt,
  input  logic pend_clr,
  output logic pend
);

  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        tc;

  // Period wrap and trigger coalescing; a new trigger in the clearing cycle survives
  always_comb begin
    tc     = (cnt_q == PERIOD_CYC - 16'd1);
    cnt_d  = tc ? '0 : cnt_q + 16'd1;
    pend_d = (pend_q & ~pend_clr) | tc | nxt;
  end

  // Trigger state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/a2d_sched.sv
// A2D scheduler: round-robins one SPI master over four A2D slots, with
// per-transaction timeout and per-slot result registers.
// Optional battery monitor: define A2D_SCHED_BATT_MON_EN to build batt_low.
module a2d_sched
  import a2d_sched_pkg::*;
#(
  parameter logic [15:0] PERIOD_CYC = 16'd2048,
  parameter logic [11:0] TMO_CYC    = 12'd1024,
  parameter logic [11:0] BATT_THRES = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld,
  output logic [1:0]  vld_ch,
  output logic        tmo,
  output logic        batt_low
);

  state_t      state_q, state_d;
  slot_t       slot_q, slot_d;
  logic [11:0] tmo_cnt_q, tmo_cnt_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        vld_q, vld_d;
  slot_t       vld_ch_q, vld_ch_d;
  logic        tmo_q, tmo_d;
  logic [11:0] lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic        pend, pend_clr, tmo_hit;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

  a2d_sched_trig #(
    .PERIOD_CYC(PERIOD_CYC)
  ) u_trig (
    .clk     (clk),
    .rst     (rst),
    .nxt     (nxt),
    .pend_clr(pend_clr),
    .pend    (pend)
  );

  // Transaction sequencing: address phase, one-cycle gap, read phase, latch
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    tmo_cnt_d = tmo_cnt_q;
    wrt_d     = 1'b0;
    cmd_d     = cmd_q;
    vld_d     = 1'b0;
    vld_ch_d  = vld_ch_q;
    tmo_d     = 1'b0;
    lft_d     = lft_q;
    rght_d    = rght_q;
    steer_d   = steer_q;
    batt_d    = batt_q;
    pend_clr  = 1'b0;
    tmo_hit   = (tmo_cnt_q == TMO_CYC - 12'd1);
    case (state_q)
      IDLE: begin
        if (pend) begin
          pend_clr  = 1'b1;
          wrt_d     = 1'b1;
          cmd_d     = slot_cmd(slot_q);
          tmo_cnt_d = '0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (done) begin
          state_d = GAP;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 12'd1;
        end
      end
      GAP: begin
        wrt_d     = 1'b1;
        tmo_cnt_d = '0;
        state_d   = READ;
      end
      READ: begin
        if (done) begin
          case (slot_q)
            2'd0:    lft_d   = rd_data[11:0];
            2'd1:    rght_d  = rd_data[11:0];
            2'd2:    steer_d = rd_data[11:0];
            default: batt_d  = rd_data[11:0];
          endcase
          state_d = LATCH;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 12'd1;
        end
      end
      LATCH: begin
        vld_d    = 1'b1;
        vld_ch_d = slot_q;
        slot_d   = slot_q + 2'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      tmo_cnt_q <= '0;
      wrt_q     <= 1'b0;
      cmd_q     <= '0;
      vld_q     <= 1'b0;
      vld_ch_q  <= '0;
      tmo_q     <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
      steer_q   <= '0;
      batt_q    <= '1;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      tmo_cnt_q <= tmo_cnt_d;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      vld_q     <= vld_d;
      vld_ch_q  <= vld_ch_d;
      tmo_q     <= tmo_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      steer_q   <= steer_d;
      batt_q    <= batt_d;
    end
  end

`ifdef A2D_SCHED_BATT_MON_EN
  logic batt_low_q, batt_low_d;

  // Re-evaluate the battery flag only once a fresh battery result is latched
  always_comb begin
    batt_low_d = batt_low_q;
    if (state_q == LATCH && slot_q == LAST_SLOT) begin
      batt_low_d = (batt_q < BATT_THRES);
    end
  end

  // Battery-low flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      batt_low_q <= 1'b0;
    end else begin
      batt_low_q <= batt_low_d;
    end
  end

  assign batt_low = batt_low_q;
`else
  logic unused_thres;
  assign unused_thres = ^BATT_THRES;
  assign batt_low     = 1'b0;
`endif

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign vld       = vld_q;
  assign vld_ch    = vld_ch_q;
  assign tmo       = tmo_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_sched.sv
// Self-checking bench for a2d_sched: SPI slave model, result scoreboard,
// table-driven conversions plus hand-written corner-case sequences.
`timescale 1ns/1ps
module tb_a2d_sched;

  typedef struct {
    logic [1:0]  slot;
    logic [11:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  slot;
    logic [11:0] data;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] steer;
    logic [11:0] batt;
  } vec_t;

`ifdef A2D_SCHED_BATT_MON_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, nxt, done;
  logic [15:0] rd_data;
  logic        wrt, vld, tmo, batt_low;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [1:0]  vld_ch;

  a2d_sched #(
    .PERIOD_CYC(16'd2048),
    .TMO_CYC   (12'd1024),
    .BATT_THRES(12'h800)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .nxt      (nxt),
    .wrt      (wrt),
    .cmd      (cmd),
    .done     (done),
    .rd_data  (rd_data),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .steer_pot(steer_pot),
    .batt     (batt),
    .vld      (vld),
    .vld_ch   (vld_ch),
    .tmo      (tmo),
    .batt_low (batt_low)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  exp_t        exp_q[$];
  logic [11:0] spi_val [4];
  logic [15:0] cmd_tab [4];
  vec_t        vec [5];

  int unsigned cyc = 0;
  int unsigned spi_st = 0;
  int unsigned spi_cnt = 0;
  int unsigned spi_dly = 2;
  int unsigned gap_cnt = 0;
  logic [15:0] spi_cmd = '0;
  logic [1:0]  cur_slot = '0;
  bit          withhold_rd = 1'b0;
  int unsigned n_vld = 0;
  int unsigned n_tmo = 0;
  int unsigned tmo_cyc = 0;
  int unsigned rd_wrt_cyc = 0;

  // Expected period counter value (restarts on reset)
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] slot_reg(input logic [1:0] s);
    case (s)
      2'd0:    return lft_ld;
      2'd1:    return rght_ld;
      2'd2:    return steer_pot;
      default: return batt;
    endcase
  endfunction

  function automatic logic exp_bl(input logic [11:0] v);
    return (v < 12'h800) & BL_EN;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wrt"},      32'(wrt),       0);
    chk({tag, "_cmd"},      32'(cmd),       0);
    chk({tag, "_vld"},      32'(vld),       0);
    chk({tag, "_vld_ch"},   32'(vld_ch),    0);
    chk({tag, "_tmo"},      32'(tmo),       0);
    chk({tag, "_lft"},      32'(lft_ld),    0);
    chk({tag, "_rght"},     32'(rght_ld),   0);
    chk({tag, "_steer"},    32'(steer_pot), 0);
    chk({tag, "_batt"},     32'(batt),      'hFFF);
    chk({tag, "_batt_low"}, 32'(batt_low),  0);
  endtask

  task automatic pulse_nxt();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [11:0] v);
    exp_t e;
    e.slot = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned target);
    int unsigned k = 0;
    while (cyc != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_cyc", cyc, target);
  endtask

  // SPI slave model and output monitor, all sampled on the falling edge
  initial begin
    exp_t e;
    done    = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (rst) begin
        spi_st   = 0;
        cur_slot = '0;
      end else begin
        if (vld) begin
          n_vld++;
          if (exp_q.size() == 0) begin
            chk("vld_unexpected", 32'(vld), 0);
          end else begin
            e = exp_q.pop_front();
            chk("vld_ch", 32'(vld_ch), 32'(e.slot));
            chk("result", 32'(slot_reg(e.slot)), 32'(e.val));
          end
          cur_slot = cur_slot + 2'd1;
        end
        if (tmo) begin
          n_tmo++;
          tmo_cyc = cyc;
          spi_st  = 0;
        end
        if (spi_st == 2) gap_cnt++;
        if (wrt) begin
          if (spi_st == 0) begin
            chk("cmd_addr", 32'(cmd), 32'(cmd_tab[cur_slot]));
            spi_cmd = cmd;
            spi_st  = 1;
            spi_cnt = spi_dly;
          end else if (spi_st == 2) begin
            chk("gap_len", gap_cnt, 2);
            chk("cmd_read", 32'(cmd), 32'(spi_cmd));
            rd_wrt_cyc = cyc;
            spi_st     = 3;
            spi_cnt    = spi_dly;
          end else begin
            chk("wrt_unexpected", 32'(wrt), 0);
          end
        end else if (spi_st == 1 || (spi_st == 3 && !withhold_rd)) begin
          if (spi_cnt == 0) begin
            chk("cmd_stable", 32'(cmd), 32'(spi_cmd));
            done = 1'b1;
            if (spi_st == 3) begin
              rd_data = {4'hF, spi_val[cur_slot]};
              spi_st  = 0;
            end else begin
              rd_data = 16'hDEAD;
              spi_st  = 2;
              gap_cnt = 0;
            end
          end else begin
            spi_cnt--;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0, t0, k;
    rst = 1'b1;
    nxt = 1'b0;
    cmd_tab[0] = 16'h0000;
    cmd_tab[1] = 16'h2000;
    cmd_tab[2] = 16'h2800;
    cmd_tab[3] = 16'h3000;
    spi_val[0] = '0;
    spi_val[1] = '0;
    spi_val[2] = '0;
    spi_val[3] = '0;
    vec[0] = '{2'd0, 12'h123, 12'h123, 12'h000, 12'h000, 12'hFFF};
    vec[1] = '{2'd1, 12'h456, 12'h123, 12'h456, 12'h000, 12'hFFF};
    vec[2] = '{2'd2, 12'h789, 12'h123, 12'h456, 12'h789, 12'hFFF};
    vec[3] = '{2'd3, 12'hABC, 12'h123, 12'h456, 12'h789, 12'hABC};
    vec[4] = '{2'd0, 12'h321, 12'h321, 12'h456, 12'h789, 12'hABC};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    // Round-robin conversions through all four slots, then wrap to slot 0
    for (int i = 0; i < 5; i++) begin
      spi_val[vec[i].slot] = vec[i].data;
      push_exp(vec[i].slot, vec[i].data);
      pulse_nxt();
      wait_drain(200);
      chk("tbl_lft",      32'(lft_ld),    32'(vec[i].lft));
      chk("tbl_rght",     32'(rght_ld),   32'(vec[i].rght));
      chk("tbl_steer",    32'(steer_pot), 32'(vec[i].steer));
      chk("tbl_batt",     32'(batt),      32'(vec[i].batt));
      chk("tbl_batt_low", 32'(batt_low),  32'(exp_bl(vec[i].batt)));
    end

    // nxt coincident with the terminal count while a conversion is running
    n0 = n_vld;
    wait_cyc(2040);
    nxt = 1'b1;
    push_exp(2'd1, spi_val[1]);
    @(negedge clk);
    nxt = 1'b0;
    wait_cyc(2047);
    chk("busy_at_tc", 32'(exp_q.size()), 1);
    nxt = 1'b1;
    push_exp(2'd2, spi_val[2]);
    @(negedge clk);
    nxt = 1'b0;
    wait_drain(300);
    repeat (60) @(negedge clk);
    chk("tc_nxt_conv", n_vld - n0, 2);

    // READ done withheld: one timeout, result kept, slot 3 retried
    withhold_rd = 1'b1;
    spi_val[3]  = 12'h7FF;
    t0 = n_tmo;
    n0 = n_vld;
    pulse_nxt();
    k = 0;
    while (n_tmo == t0 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    chk("tmo_pulses",    n_tmo - t0, 1);
    chk("tmo_delay",     tmo_cyc - rd_wrt_cyc, 1024);
    chk("tmo_batt_keep", 32'(batt), 'hABC);
    chk("tmo_no_vld",    n_vld - n0, 0);
    withhold_rd = 1'b0;
    push_exp(2'd3, 12'h7FF);
    pulse_nxt();
    wait_drain(200);
    chk("retry_batt",     32'(batt), 'h7FF);
    chk("batt_low_7ff",   32'(batt_low), 32'(exp_bl(12'h7FF)));

    // Full lap ending with battery exactly at threshold
    spi_val[0] = 12'h111;
    spi_val[1] = 12'h222;
    spi_val[2] = 12'h333;
    spi_val[3] = 12'h800;
    for (int s = 0; s < 4; s++) begin
      push_exp(2'(s), spi_val[s]);
      pulse_nxt();
      wait_drain(200);
    end
    chk("batt_800",     32'(batt), 'h800);
    chk("batt_low_800", 32'(batt_low), 32'(exp_bl(12'h800)));

    // Slot 0 conversion, then reset during the slot-1 address phase
    push_exp(2'd0, spi_val[0]);
    pulse_nxt();
    wait_drain(200);
    spi_dly = 10;
    pulse_nxt();
    k = 0;
    while (spi_st != 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("addr_seen", spi_st, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    spi_dly = 2;
    push_exp(2'd0, spi_val[0]);
    pulse_nxt();
    wait_drain(200);
    chk("post_rst_lft", 32'(lft_ld), 'h111);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
